// File: rtl/sys_result_arbiter.sv
// Result writeback arbiter: three per-channel FIFOs (GPR, SPR, CR) merged round-robin
// into one registered writeback stage with valid/ready flow control.
module sys_result_arbiter #(
  parameter int RS_ID_WIDTH = 5,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gpr_valid,
  output logic                   gpr_ready,
  input  logic [RS_ID_WIDTH-1:0] gpr_rs_id,
  input  logic [4:0]             gpr_reg_addr,
  input  logic [31:0]            gpr_result,
  input  logic                   spr_valid,
  output logic                   spr_ready,
  input  logic [RS_ID_WIDTH-1:0] spr_rs_id,
  input  logic [9:0]             spr_reg_addr,
  input  logic [31:0]            spr_result,
  input  logic                   cr_valid,
  output logic                   cr_ready,
  input  logic [7:0]             cr_enable,
  input  logic [RS_ID_WIDTH-1:0] cr_rs_id,
  input  logic [31:0]            cr_result,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [1:0]             wb_kind,
  output logic [RS_ID_WIDTH-1:0] wb_rs_id,
  output logic [9:0]             wb_reg_addr,
  output logic [7:0]             wb_cr_enable,
  output logic [31:0]            wb_result
);
  localparam int EW = RS_ID_WIDTH + 50;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Entries are stored already mapped to the writeback layout: {rs_id, reg_addr, cr_enable, result}.
  logic [EW-1:0] mem_q [3][FIFO_DEPTH];
  logic [EW-1:0] in_ent [3];
  logic [PW-1:0] wptr_q [3];
  logic [PW-1:0] wptr_d [3];
  logic [PW-1:0] rptr_q [3];
  logic [PW-1:0] rptr_d [3];
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    valid_in, full, nempty, push, pop;
  logic [1:0]    last_q, last_d, gnt_idx, cand;
  logic          gnt_vld, load;
  logic [EW-1:0] head;

  logic                   wb_valid_q, wb_valid_d;
  logic [1:0]             wb_kind_q, wb_kind_d;
  logic [RS_ID_WIDTH-1:0] wb_rs_id_q, wb_rs_id_d;
  logic [9:0]             wb_reg_addr_q, wb_reg_addr_d;
  logic [7:0]             wb_cr_enable_q, wb_cr_enable_d;
  logic [31:0]            wb_result_q, wb_result_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [1:0] rr_idx(input logic [1:0] last, input int step);
    int s;
    s = int'(last) + step;
    return 2'(s % 3);
  endfunction

  assign in_ent[0] = {gpr_rs_id, 5'b0, gpr_reg_addr, 8'b0, gpr_result};
  assign in_ent[1] = {spr_rs_id, spr_reg_addr, 8'b0, spr_result};
  assign in_ent[2] = {cr_rs_id, 10'b0, cr_enable, cr_result};
  assign valid_in  = {cr_valid, spr_valid, gpr_valid};

  assign gpr_ready = ~full[0];
  assign spr_ready = ~full[1];
  assign cr_ready  = ~full[2];
  assign load      = ~wb_valid_q | wb_ready;

  always_comb begin
    full    = '0;
    nempty  = '0;
    push    = '0;
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    for (int c = 0; c < 3; c++) begin
      full[c]   = (cnt_q[c] == CW'(FIFO_DEPTH));
      nempty[c] = (cnt_q[c] != '0);
      push[c]   = valid_in[c] & ~full[c] & ~rst;
    end
    // Walk backwards so the channel closest after the last grant wins.
    for (int i = 3; i >= 1; i--) begin
      cand = rr_idx(last_q, i);
      if (nempty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign head = mem_q[gnt_idx][rptr_q[gnt_idx]];

  always_comb begin
    pop            = '0;
    last_d         = last_q;
    wb_valid_d     = wb_valid_q;
    wb_kind_d      = wb_kind_q;
    wb_rs_id_d     = wb_rs_id_q;
    wb_reg_addr_d  = wb_reg_addr_q;
    wb_cr_enable_d = wb_cr_enable_q;
    wb_result_d    = wb_result_q;
    if (load) begin
      wb_valid_d = gnt_vld;
      if (gnt_vld) begin
        pop[gnt_idx]   = 1'b1;
        last_d         = gnt_idx;
        wb_kind_d      = gnt_idx;
        wb_rs_id_d     = head[EW-1 -: RS_ID_WIDTH];
        wb_reg_addr_d  = head[49:40];
        wb_cr_enable_d = head[39:32];
        wb_result_d    = head[31:0];
      end
    end
    for (int c = 0; c < 3; c++) begin
      wptr_d[c] = push[c] ? ptr_inc(wptr_q[c]) : wptr_q[c];
      rptr_d[c] = pop[c]  ? ptr_inc(rptr_q[c]) : rptr_q[c];
      cnt_d[c]  = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        cnt_q[c]  <= '0;
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
      last_q         <= 2'd2;
      wb_valid_q     <= 1'b0;
      wb_kind_q      <= '0;
      wb_rs_id_q     <= '0;
      wb_reg_addr_q  <= '0;
      wb_cr_enable_q <= '0;
      wb_result_q    <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        cnt_q[c]  <= cnt_d[c];
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
      end
      last_q         <= last_d;
      wb_valid_q     <= wb_valid_d;
      wb_kind_q      <= wb_kind_d;
      wb_rs_id_q     <= wb_rs_id_d;
      wb_reg_addr_q  <= wb_reg_addr_d;
      wb_cr_enable_q <= wb_cr_enable_d;
      wb_result_q    <= wb_result_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= in_ent[c];
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_kind      = wb_kind_q;
  assign wb_rs_id     = wb_rs_id_q;
  assign wb_reg_addr  = wb_reg_addr_q;
  assign wb_cr_enable = wb_cr_enable_q;
  assign wb_result    = wb_result_q;
endmodule

// File: tb/tb_sys_result_arbiter.sv
// Scoreboard bench for sys_result_arbiter: directed stimulus pushes expected writebacks,
// a negedge monitor pops and compares every accepted output.
module tb_sys_result_arbiter;
  localparam int RSW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           gpr_valid, gpr_ready;
  logic [RSW-1:0] gpr_rs_id;
  logic [4:0]     gpr_reg_addr;
  logic [31:0]    gpr_result;
  logic           spr_valid, spr_ready;
  logic [RSW-1:0] spr_rs_id;
  logic [9:0]     spr_reg_addr;
  logic [31:0]    spr_result;
  logic           cr_valid, cr_ready;
  logic [7:0]     cr_enable;
  logic [RSW-1:0] cr_rs_id;
  logic [31:0]    cr_result;
  logic           wb_valid, wb_ready;
  logic [1:0]     wb_kind;
  logic [RSW-1:0] wb_rs_id;
  logic [9:0]     wb_reg_addr;
  logic [7:0]     wb_cr_enable;
  logic [31:0]    wb_result;

  int total = 0;
  int bad   = 0;
  logic [56:0] exp_q[$];
  logic        tog_en;

  sys_result_arbiter #(.RS_ID_WIDTH(RSW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .gpr_valid(gpr_valid), .gpr_ready(gpr_ready), .gpr_rs_id(gpr_rs_id),
    .gpr_reg_addr(gpr_reg_addr), .gpr_result(gpr_result),
    .spr_valid(spr_valid), .spr_ready(spr_ready), .spr_rs_id(spr_rs_id),
    .spr_reg_addr(spr_reg_addr), .spr_result(spr_result),
    .cr_valid(cr_valid), .cr_ready(cr_ready), .cr_enable(cr_enable),
    .cr_rs_id(cr_rs_id), .cr_result(cr_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_kind(wb_kind), .wb_rs_id(wb_rs_id),
    .wb_reg_addr(wb_reg_addr), .wb_cr_enable(wb_cr_enable), .wb_result(wb_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: one transfer per negedge where valid and ready are both high.
  always @(negedge clk) begin
    if (rst === 1'b0 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
      chk("kind_legal", 64'(wb_kind == 2'b11), 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb: got kind=%0d rs=%0d result=%h, want none",
                 wb_kind, wb_rs_id, wb_result);
      end else begin
        chk("wb_record", {wb_kind, wb_rs_id, wb_reg_addr, wb_cr_enable, wb_result},
            exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    gpr_valid = 0; spr_valid = 0; cr_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    exp_q.delete();
  endtask

  function automatic logic ready_of(input int ch);
    return (ch == 0) ? gpr_ready : (ch == 1) ? spr_ready : cr_ready;
  endfunction

  task automatic drive(input int ch, input logic v, input logic [RSW-1:0] rs,
                       input logic [9:0] addr, input logic [7:0] en, input logic [31:0] res);
    if (ch == 0) begin
      gpr_valid = v; gpr_rs_id = rs; gpr_reg_addr = addr[4:0]; gpr_result = res;
    end else if (ch == 1) begin
      spr_valid = v; spr_rs_id = rs; spr_reg_addr = addr; spr_result = res;
    end else begin
      cr_valid = v; cr_rs_id = rs; cr_enable = en; cr_result = res;
    end
  endtask

  function automatic logic [56:0] exp_rec(input int ch, input logic [RSW-1:0] rs,
                                          input logic [9:0] addr, input logic [7:0] en,
                                          input logic [31:0] res);
    if (ch == 0) return {2'b00, rs, 5'b0, addr[4:0], 8'h00, res};
    if (ch == 1) return {2'b01, rs, addr, 8'h00, res};
    return {2'b10, rs, 10'h000, en, res};
  endfunction

  task automatic send(input int ch, input logic [RSW-1:0] rs, input logic [9:0] addr,
                      input logic [7:0] en, input logic [31:0] res);
    logic r;
    int n = 0;
    drive(ch, 1'b1, rs, addr, en, res);
    exp_q.push_back(exp_rec(ch, rs, addr, en, res));
    forever begin
      r = ready_of(ch);
      tick();
      if (r) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    drive(ch, 1'b0, rs, addr, en, res);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    gpr_valid = 0; gpr_rs_id = 0; gpr_reg_addr = 0; gpr_result = 0;
    spr_valid = 0; spr_rs_id = 0; spr_reg_addr = 0; spr_result = 0;
    cr_valid = 0; cr_enable = 0; cr_rs_id = 0; cr_result = 0;
    wb_ready = 1; tog_en = 0;
    rst = 1;
    tick();
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_readies", 64'({gpr_ready, spr_ready, cr_ready}), 64'b111);
    chk("rst_wb_data", 64'({wb_kind, wb_rs_id, wb_reg_addr, wb_cr_enable, wb_result}), 64'd0);
    tick();
    rst = 0;

    // Single GPR, two-cycle latency.
    wb_ready = 1;
    drive(0, 1'b1, 5'd3, 10'd7, 8'h00, 32'hDEADBEEF);
    exp_q.push_back(exp_rec(0, 5'd3, 10'd7, 8'h00, 32'hDEADBEEF));
    tick();
    drive(0, 1'b0, 5'd0, 10'd0, 8'h00, 32'h0);
    chk("no_bypass", 64'(wb_valid), 64'd0);
    tick();
    chk("gpr_valid_n1", 64'(wb_valid), 64'd1);
    chk("gpr_addr", 64'(wb_reg_addr), 64'h007);
    tick();
    chk("gpr_valid_n2", 64'(wb_valid), 64'd0);
    wait_drain("drain_single");

    // Fair arbitration across all three channels.
    do_reset();
    drive(0, 1'b1, 5'd1, 10'd5, 8'h00, 32'h11111111);
    drive(1, 1'b1, 5'd2, 10'h155, 8'h00, 32'h22222222);
    drive(2, 1'b1, 5'd4, 10'd0, 8'h81, 32'h33333333);
    exp_q.push_back(exp_rec(0, 5'd1, 10'd5, 8'h00, 32'h11111111));
    exp_q.push_back(exp_rec(1, 5'd2, 10'h155, 8'h00, 32'h22222222));
    exp_q.push_back(exp_rec(2, 5'd4, 10'd0, 8'h81, 32'h33333333));
    tick();
    gpr_valid = 0; spr_valid = 0; cr_valid = 0;
    tick(); chk("rr_kind0", 64'(wb_kind), 64'd0);
    tick(); chk("rr_kind1", 64'(wb_kind), 64'd1);
    tick(); chk("rr_kind2", 64'(wb_kind), 64'd2);
    wait_drain("drain_rr");

    // Back-pressure on SPR.
    do_reset();
    wb_ready = 0;
    send(1, 5'd1, 10'h3A5, 8'h00, 32'hA0000001);
    send(1, 5'd2, 10'h012, 8'h00, 32'hA0000002);
    send(1, 5'd3, 10'h200, 8'h00, 32'hA0000003);
    chk("bp_spr_ready", 64'(spr_ready), 64'd0);
    chk("bp_head", 64'(wb_result), 64'hA0000001);
    repeat (3) tick();
    chk("bp_hold", 64'({wb_valid, wb_kind, wb_rs_id, wb_reg_addr, wb_result}),
        64'({1'b1, 2'b01, 5'd1, 10'h3A5, 32'hA0000001}));
    chk("bp_still_full", 64'(spr_ready), 64'd0);
    wb_ready = 1;
    wait_drain("drain_bp");

    // CR mapping.
    do_reset();
    send(2, 5'd9, 10'h3FF, 8'b0010_0000, 32'h00400000);
    tick();
    chk("cr_kind", 64'(wb_kind), 64'd2);
    chk("cr_addr", 64'(wb_reg_addr), 64'd0);
    chk("cr_en", 64'(wb_cr_enable), 64'h20);
    wait_drain("drain_cr");

    // Reset mid-flight, with a valid input presented during reset.
    do_reset();
    wb_ready = 0;
    send(0, 5'd10, 10'd1, 8'h00, 32'hB0000001);
    send(0, 5'd11, 10'd2, 8'h00, 32'hB0000002);
    send(0, 5'd12, 10'd3, 8'h00, 32'hB0000003);
    chk("mf_loaded", 64'({wb_valid, gpr_ready}), 64'b10);
    rst = 1;
    drive(0, 1'b1, 5'd31, 10'd31, 8'h00, 32'hBADBAD00);
    tick();
    rst = 0;
    drive(0, 1'b0, 5'd0, 10'd0, 8'h00, 32'h0);
    exp_q.delete();
    chk("mf_wb_valid", 64'(wb_valid), 64'd0);
    chk("mf_readies", 64'({gpr_ready, spr_ready, cr_ready}), 64'b111);
    wb_ready = 1;
    tick();
    chk("mf_no_stale", 64'(wb_valid), 64'd0);
    send(0, 5'd20, 10'd20, 8'h00, 32'hC0000020);
    chk("mf_lat_n0", 64'(wb_valid), 64'd0);
    tick();
    chk("mf_lat_n1", 64'({wb_valid, wb_rs_id}), 64'({1'b1, 5'd20}));
    wait_drain("drain_mf");

    // Wrap-around: 20 GPR pushes with wb_ready toggling.
    do_reset();
    wb_ready = 1;
    tog_en = 1;
    fork
      begin
        while (tog_en) begin
          wb_ready = ~wb_ready;
          tick();
        end
      end
      begin
        for (int i = 0; i < 20; i++)
          send(0, RSW'(i), 10'(i), 8'h00, 32'h1000 + 32'(i));
        tog_en = 0;
      end
    join
    wb_ready = 1;
    wait_drain("drain_wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sys_result_arbiter.md
SYS_RESULT_ARBITER -- requirements
Module: sys_result_arbiter

Interface
REQ-001 SHALL have parameter RS_ID_WIDTH, default 5, meaning the width of the reservation-station ID.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of entries per input channel FIFO; legal values are 2 to 8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset. Synchronous, active-high.
REQ-005 SHALL have GPR input channel ports:
- gpr_valid, input, 1
- gpr_ready, output, 1
- gpr_rs_id, input, RS_ID_WIDTH
- gpr_reg_addr, input, 5
- gpr_result, input, 32
REQ-006 SHALL have SPR input channel ports:
- spr_valid, input, 1
- spr_ready, output, 1
- spr_rs_id, input, RS_ID_WIDTH
- spr_reg_addr, input, 10
- spr_result, input, 32
REQ-007 SHALL have CR input channel ports:
- cr_valid, input, 1
- cr_ready, output, 1
- cr_enable, input, 8 x 1
- cr_rs_id, input, RS_ID_WIDTH
- cr_result, input, 32
REQ-008 SHALL have writeback output ports:
- wb_valid, output, 1
- wb_ready, input, 1
- wb_kind, output, 2 (00=GPR, 01=SPR, 10=CR)
- wb_rs_id, output, RS_ID_WIDTH
- wb_reg_addr, output, 10
- wb_cr_enable, output, 8 x 1
- wb_result, output, 32

Function
REQ-009 SHALL accept a transfer on a channel when that channel's valid and ready are both high at a rising edge.
REQ-010 SHALL write each accepted transfer into that channel's own FIFO of FIFO_DEPTH entries.
REQ-011 SHALL drive each channel ready as "FIFO not full", from registered state only, with no combinational path from wb_ready or from any valid input.
REQ-012 SHALL hold the output register as a single stage; it may load when it is empty (wb_valid=0) or when it is draining (wb_valid and wb_ready both high) in the same cycle.
REQ-013 SHALL, when the output register may load, grant exactly one non-empty FIFO, pop its head, and load that entry into the output register.
REQ-014 SHALL choose the grant by round-robin over the order GPR, SPR, CR, starting with the channel after the last-granted channel.
REQ-015 SHALL update the round-robin pointer only on a grant.
REQ-016 SHALL NOT bypass an empty FIFO; minimum latency is 2 cycles: accepted at edge N, wb_valid high after edge N+1.
REQ-017 SHALL sustain a throughput of one writeback per cycle while wb_ready is held high and any FIFO is non-empty.
REQ-018 SHALL hold all wb_* outputs stable while wb_valid=1 and wb_ready=0.
REQ-019 SHALL allow a simultaneous push and pop on the same FIFO, leaving its count unchanged and preserving order.
REQ-020 SHALL keep per-channel order FIFO; no ordering guarantee exists between channels.
REQ-021 SHALL map a GPR entry onto the output as:
- wb_reg_addr = {5'b0, gpr_reg_addr}
- wb_cr_enable = all 0
REQ-022 SHALL map an SPR entry onto the output as:
- wb_reg_addr = spr_reg_addr
- wb_cr_enable = all 0
REQ-023 SHALL map a CR entry onto the output as:
- wb_reg_addr = 0
- wb_cr_enable = cr_enable
REQ-024 SHALL let FIFO read/write pointers wrap modulo FIFO_DEPTH, with a separate count distinguishing full from empty.
REQ-025 SHALL never assert wb_valid with a wb_kind of 11.

Reset
REQ-026 SHALL, while rst=1 at a rising edge, empty all FIFOs, clear wb_valid and all wb_* data to 0, and set the round-robin pointer so that GPR is next.
REQ-027 SHALL, during and right after reset, drive gpr_ready, spr_ready and cr_ready to 1.
REQ-028 SHALL, on reset asserted mid-operation, discard all buffered and in-flight entries.
REQ-029 SHALL ignore inputs in any cycle where rst=1.

Verification
REQ-030 SHALL pass single GPR: gpr rs_id=3, addr=7, result=0xDEADBEEF at edge 0 with wb_ready=1 -> wb_valid=1 after edge 1 with kind=00, rs_id=3, reg_addr=0x007, cr_enable=0, result=0xDEADBEEF; wb_valid=0 after edge 2.
REQ-031 SHALL pass fair arbitration: all three channels push one entry at edge 0 with wb_ready=1 -> wb_kind sequence 00, 01, 10 on three consecutive cycles.
REQ-032 SHALL pass back-pressure: wb_ready=0 and 3 SPR pushes with FIFO_DEPTH=2 -> spr_ready=0 after the 1st FIFO entry plus the output entry plus 1 more; the output is held unchanged; wb_ready=1 -> entries drain in push order with no loss.
REQ-033 SHALL pass CR mapping: cr_enable=8'b0010_0000, result=0x00400000 -> wb_kind=10, wb_reg_addr=0, wb_cr_enable=8'b0010_0000.
REQ-034 SHALL pass reset mid-flight: 2 entries buffered plus a valid output, then rst=1 for one edge -> wb_valid=0, all readies=1, and the next GPR push appears 2 cycles later with nothing stale.
REQ-035 SHALL pass wrap-around: 20 streamed GPR pushes with wb_ready toggling 1/0 -> all 20 are output in order, each exactly once.
